// File: rtl/dpram_burst_master_pkg.sv
// Shared widths, types and FSM encoding for the dual-port RAM burst master.
// Both the top and the read-return buffer import this package.
package dpram_burst_master_pkg;
    localparam int ADDR_W       = 8;
    localparam int BYTE         = 8;
    localparam int RD_BUF_DEPTH = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BYTE-1:0]   data_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    typedef struct packed {
        logic  last;
        data_t data;
    } rd_beat_t;
endpackage

// File: rtl/dpram_burst_master_if.sv
// Client-side streams, RAM port and status of one burst master, grouped as one bundle.
// The state field is a read-only view of the master FSM.
interface dpram_burst_master_if;
    import dpram_burst_master_pkg::*;

    // Every stream (cmd, wr, rd) moves one item on a rising edge where valid && ready;
    // a source holds valid and its payload stable until that edge, and valid never waits on ready.
    logic   cmd_valid;
    logic   cmd_ready;
    logic   cmd_write;
    addr_t  cmd_addr;
    addr_t  cmd_len;

    logic   wr_valid;
    logic   wr_ready;
    data_t  wr_data;

    logic   rd_valid;
    logic   rd_ready;
    data_t  rd_data;
    logic   rd_last;

    logic   ram_en;
    logic   ram_we;
    addr_t  ram_addr;
    data_t  ram_wdata;
    data_t  ram_rdata;

    logic   busy;
    logic   done;
    state_t state;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
        output ram_en, ram_we, ram_addr, ram_wdata, busy, done, state
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
        input  ram_en, ram_we, ram_addr, ram_wdata, busy, done, state
    );
endinterface

// File: rtl/dpram_rd_fifo.sv
// Two-entry buffer of {last, data} read beats; simultaneous push and pop keeps order.
// Callers never push into a full buffer unless the same cycle pops.
module dpram_rd_fifo
    import dpram_burst_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rd_beat_t   push_beat,
    input  logic       pop,
    output rd_beat_t   head,
    output logic [1:0] occ
);
    rd_beat_t mem [RD_BUF_DEPTH];
    logic     wr_ptr;
    logic     rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/dpram_burst_master.sv
// Burst initiator for one RAM port: takes a command, then performs one RAM access per
// cycle, bridging writes from the wr stream and returning reads through a 2-entry buffer.
module dpram_burst_master
    import dpram_burst_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    dpram_burst_master_if.master  bus
);
    state_t     state, state_nx;
    addr_t      addr_cnt;
    addr_t      beat_cnt;
    logic       inflight;
    logic       inflight_last;
    logic       done_q;
    logic [1:0] occ;
    rd_beat_t   head;
    rd_beat_t   push_beat;
    logic       last_beat, cmd_hs, wr_hs, pop, issue;

    assign last_beat = (beat_cnt == '0);
    assign cmd_hs    = (state == IDLE) && bus.cmd_valid;
    assign wr_hs     = (state == WRITE) && bus.wr_valid;
    assign pop       = (occ != 2'd0) && bus.rd_ready;
    // Issue only if the buffer can absorb this read after accounting for the one in flight.
    assign issue     = (state == READ) &&
                       (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign push_beat = '{last: inflight_last, data: bus.ram_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_cnt      <= '0;
            beat_cnt      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_nx;
            inflight      <= issue;
            inflight_last <= issue && last_beat;
            done_q        <= (wr_hs && last_beat) || (pop && head.last);
            if (cmd_hs) begin
                addr_cnt <= bus.cmd_addr;
                beat_cnt <= bus.cmd_len;
            end else if (wr_hs || issue) begin
                addr_cnt <= addr_cnt + 1'b1;
                beat_cnt <= beat_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nx = bus.cmd_write ? WRITE : READ;
            end
            WRITE: begin
                bus.wr_ready  = 1'b1;
                bus.ram_en    = bus.wr_valid;
                bus.ram_we    = bus.wr_valid;
                bus.ram_wdata = bus.wr_data;
                if (wr_hs && last_beat) state_nx = IDLE;
            end
            READ: begin
                bus.ram_en = issue;
                if (issue && last_beat) state_nx = DRAIN;
            end
            DRAIN: begin
                if (pop && head.last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    dpram_rd_fifo u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign bus.ram_addr = addr_cnt;
    assign bus.rd_valid = (occ != 2'd0);
    assign bus.rd_data  = head.data;
    assign bus.rd_last  = (occ != 2'd0) && head.last;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.state    = state;
endmodule
